// File: rtl/sa_mul_cfg_ctrl.sv
// Precision/approximation config controller for the systolic array's 8x8 signed multipliers.
// Software requests become res/appr masks, swapped in only once the array has drained.
module sa_mul_cfg_ctrl #(
  parameter int unsigned MAC_IN_WIDTH  = 8,
  parameter int unsigned MAC_OUT_WIDTH = 2 * MAC_IN_WIDTH,
  parameter int unsigned N_BIT_RES     = MAC_OUT_WIDTH - 4,
  parameter int unsigned N_BIT_APPR    = 8,
  parameter int unsigned DRAIN_CYCLES  = 4,
  parameter int unsigned CNT_W         = $clog2(DRAIN_CYCLES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [4:0]            i_cfg_res_bits,
  input  logic [3:0]            i_cfg_appr_bits,
  input  logic                  i_array_busy,
  output logic [N_BIT_RES-1:0]  o_res_mask,
  output logic [N_BIT_APPR-1:0] o_appr_mask,
  output logic                  o_cfg_applied,
  output logic                  o_cfg_err
);

  // A zero-cycle drain still needs a 1-bit counter to keep the declarations legal.
  localparam int unsigned CNT_BITS = (CNT_W > 0) ? CNT_W : 1;
  localparam logic [CNT_BITS-1:0] CNT_INIT =
      (DRAIN_CYCLES == 0) ? '0 : CNT_BITS'(DRAIN_CYCLES - 1);
  localparam logic [4:0] RES_MIN  = 5'd4;
  localparam logic [4:0] RES_MAX  = 5'(MAC_OUT_WIDTH);
  localparam logic [3:0] APPR_MAX = 4'(N_BIT_APPR);

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StDrain,
    StApply
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNT_BITS-1:0]   r_cnt;
  logic [CNT_BITS-1:0]   w_cnt_nxt;
  logic [4:0]            r_res_bits;
  logic [3:0]            r_appr_bits;
  logic [N_BIT_RES-1:0]  r_res_mask;
  logic [N_BIT_APPR-1:0] r_appr_mask;
  logic                  r_cfg_err;

  logic                  w_accept;
  logic                  w_legal;
  logic                  w_load_masks;
  logic [N_BIT_RES-1:0]  w_res_mask;
  logic [N_BIT_APPR-1:0] w_appr_mask;

  assign w_accept = i_cfg_valid && (r_state == StIdle);
  assign w_legal  = (i_cfg_res_bits >= RES_MIN) && (i_cfg_res_bits <= RES_MAX) &&
                    (i_cfg_appr_bits <= APPR_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept && w_legal) w_state_nxt = StPending;
      end
      StPending: begin
        if (!i_array_busy) begin
          if (DRAIN_CYCLES == 0) begin
            w_state_nxt = StApply;
          end else begin
            w_state_nxt = StDrain;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      StDrain: begin
        // Any busy cycle restarts the drain; busy also beats the final count.
        if (i_array_busy) begin
          w_state_nxt = StPending;
        end else if (r_cnt == '0) begin
          w_state_nxt = StApply;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      StApply: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign w_load_masks = (w_state_nxt == StApply);

  always_comb begin
    w_res_mask  = '0;
    w_appr_mask = '0;
    for (int k = 0; k < int'(N_BIT_RES); k++) begin
      w_res_mask[k] = (k + 4) < int'(r_res_bits);
    end
    for (int k = 0; k < int'(N_BIT_APPR); k++) begin
      w_appr_mask[k] = k >= int'(r_appr_bits);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_res_bits  <= RES_MAX;
      r_appr_bits <= '0;
      r_res_mask  <= '1;
      r_appr_mask <= '1;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cfg_err <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_res_bits  <= i_cfg_res_bits;
        r_appr_bits <= i_cfg_appr_bits;
      end
      if (w_load_masks) begin
        r_res_mask  <= w_res_mask;
        r_appr_mask <= w_appr_mask;
      end
    end
  end

  assign o_cfg_ready   = (r_state == StIdle);
  assign o_cfg_applied = (r_state == StApply);
  assign o_cfg_err     = r_cfg_err;
  assign o_res_mask    = r_res_mask;
  assign o_appr_mask   = r_appr_mask;

endmodule

// File: tb/tb_sa_mul_cfg_ctrl.sv
// Directed bench for sa_mul_cfg_ctrl: one 4-cycle-drain instance, one zero-drain instance.
module tb_sa_mul_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid;
  logic        valid_z;
  logic [4:0]  res_bits;
  logic [3:0]  appr_bits;
  logic        busy;

  logic        ready, applied, err;
  logic [11:0] res_mask;
  logic [7:0]  appr_mask;
  logic        ready_z, applied_z, err_z;
  logic [11:0] res_mask_z;
  logic [7:0]  appr_mask_z;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sa_mul_cfg_ctrl #(.DRAIN_CYCLES(4)) u_dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_cfg_valid    (valid),
    .o_cfg_ready    (ready),
    .i_cfg_res_bits (res_bits),
    .i_cfg_appr_bits(appr_bits),
    .i_array_busy   (busy),
    .o_res_mask     (res_mask),
    .o_appr_mask    (appr_mask),
    .o_cfg_applied  (applied),
    .o_cfg_err      (err)
  );

  sa_mul_cfg_ctrl #(.DRAIN_CYCLES(0)) u_dut_z (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_cfg_valid    (valid_z),
    .o_cfg_ready    (ready_z),
    .i_cfg_res_bits (res_bits),
    .i_cfg_appr_bits(appr_bits),
    .i_array_busy   (busy),
    .o_res_mask     (res_mask_z),
    .o_appr_mask    (appr_mask_z),
    .o_cfg_applied  (applied_z),
    .o_cfg_err      (err_z)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; sampling happens 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_masks(input string tag, input logic [11:0] rm, input logic [7:0] am);
    check_eq({tag, "_res"}, 32'(res_mask), 32'(rm));
    check_eq({tag, "_appr"}, 32'(appr_mask), 32'(am));
  endtask

  // Legal request with busy low: accept edge, then APPLY after 5 more edges.
  task automatic run_cfg(input string tag, input logic [4:0] r, input logic [3:0] a,
                         input logic [11:0] rm, input logic [7:0] am);
    valid = 1'b1; res_bits = r; appr_bits = a;
    tick();
    valid = 1'b0; res_bits = 5'd0; appr_bits = 4'd0;
    check_eq({tag, "_busy_after_accept"}, 32'(ready), 32'd0);
    repeat (4) tick();
    check_eq({tag, "_no_early_apply"}, 32'(applied), 32'd0);
    tick();
    check_eq({tag, "_applied"}, 32'(applied), 32'd1);
    check_masks(tag, rm, am);
    tick();
    check_eq({tag, "_applied_pulse"}, 32'(applied), 32'd0);
    check_eq({tag, "_ready_again"}, 32'(ready), 32'd1);
  endtask

  initial begin
    rstn = 1'b0; valid = 1'b0; valid_z = 1'b0; busy = 1'b0;
    res_bits = 5'd0; appr_bits = 4'd0;
    #23 rstn = 1'b1;
    tick();

    // Reset state
    check_masks("rst", 12'hFFF, 8'hFF);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_applied", 32'(applied), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);

    // Basic latency, R=8 A=3
    valid = 1'b1; res_bits = 5'd8; appr_bits = 4'd3;
    tick();
    valid = 1'b0; res_bits = 5'd0; appr_bits = 4'd0;
    check_eq("lat_ready_low", 32'(ready), 32'd0);
    repeat (4) tick();
    check_eq("lat_t4_applied", 32'(applied), 32'd0);
    check_masks("lat_t4_old", 12'hFFF, 8'hFF);
    tick();
    check_eq("lat_t5_applied", 32'(applied), 32'd1);
    check_masks("lat_t5", 12'h00F, 8'hF8);
    check_eq("lat_t5_ready", 32'(ready), 32'd0);
    tick();
    check_eq("lat_t6_ready", 32'(ready), 32'd1);
    check_eq("lat_t6_applied", 32'(applied), 32'd0);

    // Async reset mid-drain
    valid = 1'b1; res_bits = 5'd5; appr_bits = 4'd1;
    tick();
    valid = 1'b0;
    tick(); tick();
    #2 rstn = 1'b0;
    #1;
    check_masks("arst", 12'hFFF, 8'hFF);
    check_eq("arst_ready", 32'(ready), 32'd1);
    check_eq("arst_applied", 32'(applied), 32'd0);
    check_eq("arst_err", 32'(err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Drain restart on busy
    busy = 1'b1; valid = 1'b1; res_bits = 5'd10; appr_bits = 4'd2;
    tick();
    valid = 1'b0;
    repeat (10) tick();
    check_eq("busy_hold_applied", 32'(applied), 32'd0);
    check_masks("busy_hold", 12'hFFF, 8'hFF);
    busy = 1'b0;
    tick(); tick();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("restart_no_apply", 32'(applied), 32'd0);
    end
    check_masks("restart_old", 12'hFFF, 8'hFF);
    tick();
    check_eq("restart_applied", 32'(applied), 32'd1);
    check_masks("restart", 12'h03F, 8'hFC);
    tick();

    // Busy wins over the final drain count
    valid = 1'b1; res_bits = 5'd16; appr_bits = 4'd0;
    tick();
    valid = 1'b0;
    repeat (4) tick();
    busy = 1'b1;
    tick();
    check_eq("busy_wins_applied", 32'(applied), 32'd0);
    check_eq("busy_wins_ready", 32'(ready), 32'd0);
    busy = 1'b0;
    repeat (5) tick();
    check_eq("busy_wins_late_apply", 32'(applied), 32'd1);
    check_masks("busy_wins", 12'hFFF, 8'hFF);
    tick();
    run_cfg("r10a2", 5'd10, 4'd2, 12'h03F, 8'hFC);

    // Illegal requests
    valid = 1'b1; res_bits = 5'd3; appr_bits = 4'd0;
    tick();
    valid = 1'b0;
    check_eq("ill_r3_err", 32'(err), 32'd1);
    check_eq("ill_r3_ready", 32'(ready), 32'd1);
    tick();
    check_eq("ill_r3_err_clr", 32'(err), 32'd0);
    check_masks("ill_r3", 12'h03F, 8'hFC);
    valid = 1'b1; res_bits = 5'd12; appr_bits = 4'd9;
    tick();
    valid = 1'b0;
    check_eq("ill_a9_err", 32'(err), 32'd1);
    check_eq("ill_a9_ready", 32'(ready), 32'd1);
    tick();
    check_eq("ill_a9_err_clr", 32'(err), 32'd0);
    check_eq("ill_a9_applied", 32'(applied), 32'd0);
    check_masks("ill_a9", 12'h03F, 8'hFC);
    valid = 1'b1; res_bits = 5'd17; appr_bits = 4'd0;
    tick();
    valid = 1'b0;
    check_eq("ill_r17_err", 32'(err), 32'd1);
    tick();

    // Corners
    run_cfg("r16a0", 5'd16, 4'd0, 12'hFFF, 8'hFF);
    run_cfg("r4a8", 5'd4, 4'd8, 12'h000, 8'h00);
    run_cfg("r5a7", 5'd5, 4'd7, 12'h001, 8'h80);

    // Zero-drain instance applies one edge after accept
    valid_z = 1'b1; res_bits = 5'd8; appr_bits = 4'd3;
    tick();
    valid_z = 1'b0;
    check_eq("z_t0_applied", 32'(applied_z), 32'd0);
    check_eq("z_t0_ready", 32'(ready_z), 32'd0);
    tick();
    check_eq("z_t1_applied", 32'(applied_z), 32'd1);
    check_eq("z_t1_res", 32'(res_mask_z), 32'h00F);
    check_eq("z_t1_appr", 32'(appr_mask_z), 32'hF8);
    tick();
    check_eq("z_t2_ready", 32'(ready_z), 32'd1);

    // Valid held across two back-to-back configs
    valid = 1'b1; res_bits = 5'd6; appr_bits = 4'd1;
    tick();
    res_bits = 5'd14; appr_bits = 4'd5;
    repeat (4) tick();
    check_eq("b2b_first_not_yet", 32'(applied), 32'd0);
    tick();
    check_eq("b2b_first_applied", 32'(applied), 32'd1);
    check_masks("b2b_first", 12'h003, 8'hFE);
    tick();
    check_eq("b2b_idle_ready", 32'(ready), 32'd1);
    tick();
    valid = 1'b0;
    check_eq("b2b_second_accepted", 32'(ready), 32'd0);
    check_masks("b2b_hold", 12'h003, 8'hFE);
    repeat (4) tick();
    check_eq("b2b_second_not_yet", 32'(applied), 32'd0);
    tick();
    check_eq("b2b_second_applied", 32'(applied), 32'd1);
    check_masks("b2b_final", 12'h3FF, 8'hE0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    $fatal(1);
  end

endmodule
